// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-neuron datapath.
package bnn_pkg;

    parameter int unsigned ACC_W = 7;
    parameter int ACC_MAX = 63;
    parameter int ACC_MIN = -64;

    typedef enum logic {
        StAccum,
        StHold
    } acc_state_e;

endpackage

// File: rtl/sat_add_7b.sv
// Combinational signed add that clamps to the representable range and flags overflow.
module sat_add_7b #(
    parameter int unsigned W = bnn_pkg::ACC_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw;

    always_comb begin
        raw   = a_i + b_i;
        // Like-signed operands producing an opposite-signed result have wrapped.
        ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
        if (ovf_o) begin
            sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_o = raw;
        end
    end

endmodule

// File: rtl/bnn_popcount_acc.sv
// Saturating signed accumulator for one binary neuron: sums +/-1 product bits onto a bias
// and presents the final sum, its sign and a sticky saturation flag.
module bnn_popcount_acc #(
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sign,
    output logic             out_sat
);

    import bnn_pkg::*;

    function automatic logic [ACC_W-1:0] popcount(input logic [N-1:0] bits);
        logic [ACC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt = cnt + ACC_W'(bits[i]);
        end
        return cnt;
    endfunction

    acc_state_e       state_q, state_d;
    logic             first_q, first_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic [ACC_W-1:0] contrib;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_next;
    logic             acc_ovf;
    logic             accept;

    // 2*popcount - N, wrapping arithmetic yields the two's-complement contribution.
    assign contrib  = (popcount(in_bits) << 1) - ACC_W'(N);
    assign acc_base = first_q ? bias : acc_q;
    assign accept   = in_valid && (state_q == StAccum);

    sat_add_7b #(
        .W (ACC_W)
    ) u_sat_add (
        .a_i   (acc_base),
        .b_i   (contrib),
        .sum_o (acc_next),
        .ovf_o (acc_ovf)
    );

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        sat_d   = sat_q;
        acc_d   = acc_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d   = acc_next;
                    first_d = 1'b0;
                    // A first beat starts a fresh neuron, so prior stickiness is dropped.
                    sat_d   = (first_q ? 1'b0 : sat_q) | acc_ovf;
                    if (in_last) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAccum;
                    first_d = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            first_q <= 1'b1;
            sat_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StHold);
    assign out_sum   = acc_q;
    assign out_sign  = ~acc_q[ACC_W-1];
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_bnn_popcount_acc.sv
// Directed bench for bnn_popcount_acc with an integer reference model checked every cycle.
module tb_bnn_popcount_acc;

    logic       clk;
    logic       rst;
    logic [6:0] bias;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bits;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_sum;
    logic       out_sign;
    logic       out_sat;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    // Reference model state in plain integers.
    bit m_hold  = 0;
    bit m_first = 1;
    bit m_sat   = 0;
    int m_acc   = 0;

    bnn_popcount_acc #(
        .N     (4),
        .ACC_W (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sign  (out_sign),
        .out_sat   (out_sat)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hold  = 0;
            m_first = 1;
            m_sat   = 0;
            m_acc   = 0;
        end else if (!m_hold && in_valid) begin
            int s;
            s = (m_first ? int'($signed(bias)) : m_acc) + 2 * $countones(in_bits) - 4;
            if (m_first) m_sat = 0;
            if (s > 63) begin s = 63; m_sat = 1; end
            if (s < -64) begin s = -64; m_sat = 1; end
            m_acc   = s;
            m_first = 0;
            if (in_last) m_hold = 1;
        end else if (m_hold && out_ready) begin
            m_hold  = 0;
            m_first = 1;
            m_sat   = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready", int'(in_ready), int'(!m_hold));
            check("out_valid", int'(out_valid), int'(m_hold));
            if (m_hold) begin
                check("out_sum", int'($signed(out_sum)), m_acc);
                check("out_sign", int'(out_sign), int'(m_acc >= 0));
                check("out_sat", int'(out_sat), int'(m_sat));
            end
        end
    end

    // Called at a negedge; the following posedge samples the beat.
    task automatic send(input int b, input logic [3:0] bits, input logic last);
        bias     = 7'(b);
        in_bits  = bits;
        in_last  = last;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic release_out();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic expect_result(input string name, input int sum, input int sat);
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_sum"}, int'($signed(out_sum)), sum);
        check({name, "_sign"}, int'(out_sign), int'(sum >= 0));
        check({name, "_sat"}, int'(out_sat), sat);
    endtask

    initial begin
        logic [6:0] held_sum;
        rst = 1; bias = '0; in_valid = 0; in_bits = '0; in_last = 0; out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_sign", int'(out_sign), 1);
        check("rst_out_sat", int'(out_sat), 0);
        rst = 0;
        started = 1;

        send(10, 4'b1111, 0); send(10, 4'b1111, 0); send(10, 4'b1111, 1);
        expect_result("t1", 22, 0);
        release_out();

        send(60, 4'b1111, 0); send(60, 4'b1111, 1);
        expect_result("t2", 63, 1);
        release_out();

        send(-60, 4'b0000, 0); send(-60, 4'b0000, 1);
        expect_result("t3", -64, 1);
        check("t3_bits", int'(out_sum), 7'b1000000);
        release_out();

        send(0, 4'b1010, 1);
        expect_result("t4a", 0, 0);
        release_out();
        send(-1, 4'b0111, 1);
        expect_result("t4b", 1, 0);

        // Hold with backpressure; an in_valid pulse must be ignored.
        held_sum = out_sum;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1; in_bits = 4'b1111; in_last = 1;
            end
            @(negedge clk);
            in_valid = 0; in_last = 0;
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_stable", int'(out_sum), int'(held_sum));
        end
        release_out();
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);

        // Bias changes after the first beat are ignored.
        send(5, 4'b1111, 0); send(50, 4'b1100, 1);
        expect_result("bias_once", 9, 0);
        release_out();

        // Saturation flag stays set after the sum recovers.
        send(62, 4'b1111, 0); send(0, 4'b0000, 1);
        expect_result("sticky", 59, 1);
        release_out();

        // Reset mid-neuron discards the partial sum.
        send(20, 4'b1111, 0); send(20, 4'b1111, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_sum", int'(out_sum), 0);
        @(negedge clk);
        check("abort_no_valid", int'(out_valid), 0);
        send(0, 4'b0011, 1);
        expect_result("after_abort", 0, 0);

        // Reset while holding a result.
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("hold_rst_valid", int'(out_valid), 0);
        check("hold_rst_ready", int'(in_ready), 1);
        send(-3, 4'b0001, 1);
        expect_result("post_hold_rst", -5, 0);
        release_out();

        @(negedge clk);
        started = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bnn_popcount_acc.md
# bnn_popcount_acc

Sequential signed accumulator for one binary neuron. It consumes a stream of XNOR product bits, where each bit means +1 or −1. It adds them onto a 7-bit two's-complement bias-initialised sum using saturating 7-bit arithmetic, and emits the final sum plus its binarised sign. It sits between the XNOR product stage and the next layer's activation register in the MLP datapath.

## Interface
- `N`, default 4: product bits per input beat.
- `ACC_W`, default 7: accumulator width (signed).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `bias` in ACC_W: signed neuron bias; sampled on the first accepted beat of a neuron.
- `in_valid` in 1: beat present.
- `in_ready` out 1: block accepts a beat.
- `in_bits` in N: product bits; 1 = +1, 0 = −1.
- `in_last` in 1: final beat of the neuron.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out ACC_W: signed final sum.
- `out_sign` out 1: 1 when out_sum ≥ 0, else 0.
- `out_sat` out 1: saturation occurred at any point during this neuron.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM with `first` = 1, acc = 0, sat = 0.
- Beat contribution: c = 2·popcount(in_bits) − N.
  - Range is −N..+N.
  - Computed at ACC_W width with sign extension.
- Accept occurs when `in_valid && in_ready`. `in_ready` = (state == ACCUM).
  - If `first`: acc_next = sat_add(bias, c).
  - Otherwise: acc_next = sat_add(acc, c).
  - `first` is cleared on accept.
- Saturating add:
  - If the true sum > +2^(ACC_W−1)−1 (63), clamp to 63.
  - If the true sum < −2^(ACC_W−1) (−64), clamp to −64.
  - Overflow is detected when operand signs are equal and the result sign differs.
  - On clamp, sat becomes 1 and stays sticky until the neuron ends.
- Accept with `in_last`:
  - Register acc_next into acc.
  - Move to HOLD and raise `out_valid`.
- HOLD:
  - out_sum = acc, out_sign = ~acc[ACC_W−1], out_sat = sat.
  - Stable while `out_ready` = 0.
- `out_valid && out_ready`: return to ACCUM with `first` = 1 and sat = 0. acc is left unchanged; it is overwritten by the next first beat.
- Input is not accepted in HOLD (`in_ready` = 0), so an input beat and an output handshake cannot occur in the same cycle.
- A single-beat neuron (`in_last` on the first beat) is legal: result = sat_add(bias, c).
- `bias` is sampled only on the first beat. Changes to it mid-neuron are ignored.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_sign` = 1, `out_sat` = 0.
- Throughput: one beat per cycle in ACCUM.
- Latency: `out_valid` asserts the cycle after the accept of the `in_last` beat.
- Minimum gap: one HOLD cycle between neurons, i.e. `in_ready` is low for at least one cycle.
- Reset mid-neuron, in either state: the partial sum is discarded, sat is cleared, and the block returns to ACCUM/first on the next edge. No `out_valid` is produced for the aborted neuron.
- All outputs are registered. There is no combinational path from `in_*` to `out_*`.

## Structure
- Package `bnn_pkg`:
  - ACC_W
  - ACC_MAX = 63
  - ACC_MIN = −64
  - a state enum (ACCUM, HOLD)
- Sub-module `sat_add_7b`: combinational signed add with clamp and an overflow flag. It is reused by later bias/threshold stages.
- Popcount is an inline function in the top module.

## Test plan
- bias = 10; beats 1111, 1111, 1111 (last) → out_sum = 22, out_sign = 1, out_sat = 0, `out_valid` 1 cycle after the last accept.
- bias = 60; beats 1111, 1111 (last) → out_sum = 63, out_sat = 1, out_sign = 1.
- bias = −60; beats 0000, 0000 (last) → out_sum = −64 (1000000), out_sat = 1, out_sign = 0.
- bias = 0; single beat 1010 with last → out_sum = 0, out_sign = 1. Then bias = −1; single beat 0111 with last → out_sum = 1.
- HOLD with `out_ready` = 0 for 5 cycles: outputs stable, `in_ready` = 0, and an `in_valid` pulse is not consumed. Raising `out_ready` returns the block to ACCUM on the next cycle.
- `rst` asserted after 2 of 3 beats (bias = 20, beats 1111) → no `out_valid`. A fresh neuron with bias = 0 and 0011 (last) then yields out_sum = 0, out_sat = 0.
